// File: rtl/audio_gain_ctrl.sv
// Per-frame soft-ramped digital volume with soft mute for the WM8978 ADC->DAC path.
// Samples are tagged L/R, scaled by cur_gain/2^FRAC, floored, saturated and flagged on clip.
module audio_gain_ctrl #(
  parameter int DW   = 32,
  parameter int GW   = 6,
  parameter int FRAC = 5
) (
  input  logic          aud_bclk,
  input  logic          rst,
  input  logic          rx_done,
  input  logic [DW-1:0] adc_data,
  input  logic [GW-1:0] vol,
  input  logic          mute,
  input  logic          clr_clip,
  output logic          tx_valid,
  output logic [DW-1:0] dac_data,
  output logic          tx_chan,
  output logic [GW-1:0] cur_gain,
  output logic          clip
);

  localparam int PW = DW + GW + 1;
  localparam int SW = PW - FRAC;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } ramp_state_t;

  ramp_state_t r_state;
  logic [GW-1:0] r_gain;
  logic [GW-1:0] w_target;

  logic          r_chan;
  logic          r_s1_valid;
  logic [DW-1:0] r_s1_data;
  logic          r_s1_chan;
  logic [GW-1:0] r_s1_gain;

  logic                 r_s2_valid;
  logic                 r_s2_chan;
  logic signed [PW-1:0] r_s2_prod;

  logic          r_s3_valid;
  logic          r_s3_chan;
  logic [SW-1:0] r_s3_val;

  logic          r_tx_valid;
  logic [DW-1:0] r_dac_data;
  logic          r_tx_chan;
  logic          r_clip;

  logic signed [PW-1:0] w_data_x;
  logic signed [PW-1:0] w_gain_x;
  logic [DW:0]          w_sat;
  logic                 w_sat_hit;
  logic [DW-1:0]        w_sat_data;

  // Clamp an SW-bit signed value into DW bits; MSB of the result flags a clamp.
  function automatic logic [DW:0] saturate(input logic [SW-1:0] v);
    logic [SW-DW:0] upper;
    logic [DW:0]    res;
    upper = v[SW-1:DW-1];
    if ((upper == {(SW-DW+1){1'b0}}) || (upper == {(SW-DW+1){1'b1}})) begin
      res = {1'b0, v[DW-1:0]};
    end else if (v[SW-1]) begin
      res = {1'b1, 1'b1, {(DW-1){1'b0}}};
    end else begin
      res = {1'b1, 1'b0, {(DW-1){1'b1}}};
    end
    return res;
  endfunction

  assign w_target   = mute ? {GW{1'b0}} : vol;
  assign w_data_x   = $signed({{(GW+1){r_s1_data[DW-1]}}, r_s1_data});
  assign w_gain_x   = $signed({{(DW+1){1'b0}}, r_s1_gain});
  assign w_sat      = saturate(r_s3_val);
  assign w_sat_hit  = w_sat[DW];
  assign w_sat_data = w_sat[DW-1:0];

  // Gain ramp: one step per frame, decided when the right sample enters S1.
  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      r_state <= ST_HOLD;
      r_gain  <= {GW{1'b0}};
    end else if (rx_done && r_chan) begin
      if (r_gain < w_target) begin
        r_state <= ST_UP;
        r_gain  <= r_gain + {{(GW-1){1'b0}}, 1'b1};
      end else if (r_gain > w_target) begin
        r_state <= ST_DOWN;
        r_gain  <= r_gain - {{(GW-1){1'b0}}, 1'b1};
      end else begin
        r_state <= ST_HOLD;
        r_gain  <= r_gain;
      end
    end else begin
      r_state <= r_state;
      r_gain  <= r_gain;
    end
  end

  // S1 capture and L/R toggle.
  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      r_chan     <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= {DW{1'b0}};
      r_s1_chan  <= 1'b0;
      r_s1_gain  <= {GW{1'b0}};
    end else begin
      r_s1_valid <= rx_done;
      if (rx_done) begin
        r_s1_data <= adc_data;
        r_s1_chan <= r_chan;
        r_s1_gain <= r_gain;
        r_chan    <= ~r_chan;
      end else begin
        r_chan    <= r_chan;
      end
    end
  end

  // S2 multiply and S3 floor shift (dropping FRAC low bits is an arithmetic floor).
  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_chan  <= 1'b0;
      r_s2_prod  <= {PW{1'b0}};
      r_s3_valid <= 1'b0;
      r_s3_chan  <= 1'b0;
      r_s3_val   <= {SW{1'b0}};
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_chan  <= r_s1_chan;
      r_s2_prod  <= w_data_x * w_gain_x;
      r_s3_valid <= r_s2_valid;
      r_s3_chan  <= r_s2_chan;
      r_s3_val   <= r_s2_prod[PW-1:FRAC];
    end
  end

  // Output register with saturation; a new clip beats a simultaneous clear.
  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      r_tx_valid <= 1'b0;
      r_dac_data <= {DW{1'b0}};
      r_tx_chan  <= 1'b0;
      r_clip     <= 1'b0;
    end else begin
      r_tx_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_dac_data <= w_sat_data;
        r_tx_chan  <= r_s3_chan;
      end else begin
        r_dac_data <= r_dac_data;
        r_tx_chan  <= r_tx_chan;
      end
      if (r_s3_valid && w_sat_hit) begin
        r_clip <= 1'b1;
      end else if (clr_clip) begin
        r_clip <= 1'b0;
      end else begin
        r_clip <= r_clip;
      end
    end
  end

  assign tx_valid = r_tx_valid;
  assign dac_data = r_dac_data;
  assign tx_chan  = r_tx_chan;
  assign cur_gain = r_gain;
  assign clip     = r_clip;

endmodule

// File: tb/tb_audio_gain_ctrl.sv
// Scoreboard bench for audio_gain_ctrl: a behavioural gain/channel model queues expected
// outputs (data, channel, saturation, output edge) and a negedge monitor checks them.
module tb_audio_gain_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [31:0] adc_data = 32'h0;
  logic [5:0]  vol = 6'd0;
  logic        mute = 1'b0;
  logic        clr_clip = 1'b0;
  logic        tx_valid;
  logic [31:0] dac_data;
  logic        tx_chan;
  logic [5:0]  cur_gain;
  logic        clip;

  always #5 clk = ~clk;

  audio_gain_ctrl #(.DW(32), .GW(6), .FRAC(5)) dut (
    .aud_bclk (clk),
    .rst      (rst),
    .rx_done  (rx_done),
    .adc_data (adc_data),
    .vol      (vol),
    .mute     (mute),
    .clr_clip (clr_clip),
    .tx_valid (tx_valid),
    .dac_data (dac_data),
    .tx_chan  (tx_chan),
    .cur_gain (cur_gain),
    .clip     (clip)
  );

  typedef struct {
    logic [31:0] data;
    logic        chan;
    logic        sat;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   m_gain = 0;
  logic m_chan = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference: sample * gain, floored divide by 32, clamp to 32-bit signed.
  function automatic exp_t model_out(input logic [31:0] s, input int g);
    exp_t   e;
    longint sv;
    longint p;
    sv = longint'($signed(s));
    p  = (sv * longint'(g)) >>> 5;
    e.sat = 1'b0;
    if (p > 64'sd2147483647) begin
      e.data = 32'h7FFFFFFF;
      e.sat  = 1'b1;
    end else if (p < -64'sd2147483648) begin
      e.data = 32'h80000000;
      e.sat  = 1'b1;
    end else begin
      e.data = p[31:0];
    end
    e.chan    = 1'b0;
    e.edge_no = 0;
    return e;
  endfunction

  // Drive one sample (call just after a negedge) and record its expected output.
  task automatic push_sample(input logic [31:0] s);
    exp_t e;
    int   tgt;
    rx_done  = 1'b1;
    adc_data = s;
    e = model_out(s, m_gain);
    e.chan    = m_chan;
    e.edge_no = edge_cnt + 4;
    sb.push_back(e);
    if (m_chan) begin
      tgt = mute ? 0 : int'(vol);
      if (m_gain < tgt) m_gain = m_gain + 1;
      else if (m_gain > tgt) m_gain = m_gain - 1;
    end
    m_chan = ~m_chan;
  endtask

  task automatic send(input logic [31:0] s);
    @(negedge clk);
    push_sample(s);
    @(negedge clk);
    rx_done = 1'b0;
    total++;
    if (cur_gain !== m_gain[5:0]) begin
      bad++;
      $display("FAIL cur_gain: got %0d want %0d", cur_gain, m_gain);
    end
  endtask

  task automatic send_frame(input logic [31:0] s);
    send(s);
    send(s);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, got, want);
    end
  endtask

  // Monitor: every tx_valid must match the next expected entry, at the right edge.
  always @(negedge clk) begin
    if (tx_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tx: got data %h with empty scoreboard", dac_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dac_data !== e.data || tx_chan !== e.chan || edge_cnt != e.edge_no ||
            (e.sat && clip !== 1'b1)) begin
          bad++;
          $display("FAIL tx_out: got data=%h chan=%0b edge=%0d clip=%0b want data=%h chan=%0b edge=%0d sat=%0b",
                   dac_data, tx_chan, edge_cnt, clip, e.data, e.chan, e.edge_no, e.sat);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    total++;
    if (tx_valid !== 1'b0 || dac_data !== 32'h0 || tx_chan !== 1'b0 ||
        cur_gain !== 6'd0 || clip !== 1'b0) begin
      bad++;
      $display("FAIL %s: got v=%0b d=%h c=%0b g=%0d clip=%0b want all zero",
               name, tx_valid, dac_data, tx_chan, cur_gain, clip);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    m_gain = 0;
    m_chan = 1'b0;
  endtask

  task automatic test_ramp_up();
    vol  = 6'd32;
    mute = 1'b0;
    for (int n = 0; n < 40; n++) send_frame(32'h10000000);
    drain();
    total++;
    if (cur_gain !== 6'd32) begin
      bad++;
      $display("FAIL ramp_settle: got %0d want 32", cur_gain);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      push_sample(32'(i));
    end
    @(negedge clk);
    rx_done = 1'b0;
    drain();
  endtask

  task automatic test_soft_mute();
    mute = 1'b1;
    for (int n = 0; n < 34; n++) send_frame(32'h10000000);
    drain();
    total++;
    if (cur_gain !== 6'd0) begin
      bad++;
      $display("FAIL mute_gain: got %0d want 0", cur_gain);
    end
    mute = 1'b0;
    vol  = 6'd10;
    for (int n = 0; n < 13; n++) send_frame(32'h10000000);
    drain();
    total++;
    if (cur_gain !== 6'd10) begin
      bad++;
      $display("FAIL unmute_gain: got %0d want 10", cur_gain);
    end
  endtask

  task automatic test_saturation();
    vol = 6'd63;
    for (int n = 0; n < 70 && m_gain != 63; n++) send_frame(32'h00001000);
    drain();
    check_bit("clip_before_sat", clip, 1'b0);
    send(32'h7FFFFFFF);
    send(32'h80000000);
    drain();
    check_bit("clip_after_sat", clip, 1'b1);
    @(negedge clk);
    clr_clip = 1'b1;
    @(negedge clk);
    clr_clip = 1'b0;
    check_bit("clip_cleared", clip, 1'b0);
    // Clear lands on the same edge as a saturating output.
    send(32'h7FFFFFFF);
    @(negedge clk);
    @(negedge clk);
    clr_clip = 1'b1;
    @(negedge clk);
    clr_clip = 1'b0;
    check_bit("clip_set_wins_valid", tx_valid, 1'b1);
    check_bit("clip_set_wins", clip, 1'b1);
    send(32'h80000000);
    drain();
  endtask

  task automatic test_arith_shift();
    vol = 6'd16;
    for (int n = 0; n < 60 && m_gain != 16; n++) send_frame(32'h00000100);
    drain();
    @(negedge clk);
    clr_clip = 1'b1;
    @(negedge clk);
    clr_clip = 1'b0;
    check_bit("shift_clip_clr", clip, 1'b0);
    send(32'hFFFFFFFF);
    send(32'h00000001);
    drain();
    total++;
    if (dac_data !== 32'h0) begin
      bad++;
      $display("FAIL shift_pos: got %h want 00000000", dac_data);
    end
    check_bit("shift_no_clip", clip, 1'b0);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    push_sample(32'h11111111);
    @(negedge clk);
    push_sample(32'h22222222);
    @(negedge clk);
    rx_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_gain = 0;
    m_chan = 1'b0;
    check_reset_outputs("reset_midflight");
    repeat (5) @(negedge clk);
    send(32'h12345678);
    drain();
    check_bit("post_reset_chan", tx_chan, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_back_to_back();
    test_soft_mute();
    test_saturation();
    test_arith_shift();
    test_reset_midflight();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
